// File: rtl/phase_drive_gen_pkg.sv
// Shared types and constants for the CDU timing blocks: phase slots,
// zero-drive FSM states and the per-slot drive pattern helper.
package cdu_timing_pkg;

  localparam int NUM_PHASES = 4;

  typedef enum logic [1:0] {
    FAZ1 = 2'd0,
    FAZ2 = 2'd1,
    FAZ3 = 2'd2,
    FAZ4 = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    Z_IDLE    = 2'd0,
    Z_WAIT    = 2'd1,
    Z_HOLD    = 2'd2,
    Z_RELEASE = 2'd3
  } zstate_t;

  // Active-low drive vector for one slot: bit n low selects FAZ(n+1)DR.
  function automatic logic [NUM_PHASES-1:0] phaseDriveLow(input phase_t slot);
    return ~(NUM_PHASES'(1) << slot);
  endfunction

endpackage

// File: rtl/phase_drive_gen_if.sv
// Run/zero request inputs and the active-low drive outputs of the CDU
// phase and moding source, grouped so controller and generator share one bundle.
interface phase_drive_gen_if;
  import cdu_timing_pkg::*;

  logic       en;
  logic       ISSZ;
  logic       FAZ1DR;
  logic       FAZ2DR;
  logic       FAZ2DR_n;
  logic       FAZ3DR;
  logic       FAZ4DR;
  logic       ISSZDR;
  logic [1:0] phase;
  logic       cyc_start;

  modport master (
    output en,
    output ISSZ,
    input  FAZ1DR,
    input  FAZ2DR,
    input  FAZ2DR_n,
    input  FAZ3DR,
    input  FAZ4DR,
    input  ISSZDR,
    input  phase,
    input  cyc_start
  );

  modport slave (
    input  en,
    input  ISSZ,
    output FAZ1DR,
    output FAZ2DR,
    output FAZ2DR_n,
    output FAZ3DR,
    output FAZ4DR,
    output ISSZDR,
    output phase,
    output cyc_start
  );

endinterface

// File: rtl/phase_drive_gen_sync2.sv
// Two-flop synchronizer for asynchronous AGC moding inputs; both stages
// come out of reset at RESET_VAL so an idle active-low request reads inactive.
module cdu_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/phase_drive_gen.sv
// Four-phase drive generator and ISS zero drive for the CDU buffers.
// Slot state is advanced by a divider; all outputs are registered.
module phase_drive_gen
  import cdu_timing_pkg::*;
#(
  parameter int DIV       = 4,
  parameter int ZERO_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  phase_drive_gen_if.slave  bus
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(ZERO_HOLD + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ZERO_HOLD);

  logic [DIV_W-1:0]      div_q, div_d;
  phase_t                slot_q, slot_d;
  zstate_t               zState_q, zState_d;
  logic [CNT_W-1:0]      holdCnt_q, holdCnt_d;

  logic [NUM_PHASES-1:0] fazDr_q, fazDr_d;
  logic                  faz2n_q;
  logic                  isszDr_q, isszDr_d;
  phase_t                phaseOut_q;
  logic                  cycStart_q, cycStart_d;

  logic                  isszSync;
  logic                  zReq;

  cdu_sync2 #(
    .RESET_VAL (1'b1)
  ) u_issz_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.ISSZ),
    .sync_o  (isszSync)
  );

  assign zReq = ~isszSync;

  // Outputs registered at an edge describe the slot held before that edge.
  always_comb begin
    div_d      = div_q;
    slot_d     = slot_q;
    cycStart_d = bus.en && (slot_q == FAZ1) && (div_q == '0);
    fazDr_d    = bus.en ? phaseDriveLow(slot_q) : '1;
    if (bus.en) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        slot_d = phase_t'(slot_q + 2'd1);
      end else begin
        div_d  = div_q + DIV_W'(1);
      end
    end
  end

  always_comb begin
    zState_d  = zState_q;
    holdCnt_d = holdCnt_q;
    isszDr_d  = isszDr_q;
    unique case (zState_q)
      Z_IDLE: begin
        if (zReq) zState_d = Z_WAIT;
      end
      Z_WAIT: begin
        if (!zReq) begin
          zState_d = Z_IDLE;
        end else if (cycStart_d) begin
          zState_d  = Z_HOLD;
          holdCnt_d = CNT_W'(1);
          isszDr_d  = 1'b0;
        end
      end
      Z_HOLD: begin
        if (holdCnt_q >= CNT_MAX) begin
          zState_d = Z_RELEASE;
        end else begin
          holdCnt_d = holdCnt_q + CNT_W'(1);
        end
      end
      Z_RELEASE: begin
        // Release only on a cycle boundary once the request has gone away.
        if (cycStart_d && !zReq) begin
          zState_d = Z_IDLE;
          isszDr_d = 1'b1;
        end
      end
      default: zState_d = Z_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      slot_q     <= FAZ1;
      zState_q   <= Z_IDLE;
      holdCnt_q  <= '0;
      fazDr_q    <= '1;
      faz2n_q    <= 1'b0;
      isszDr_q   <= 1'b1;
      phaseOut_q <= FAZ1;
      cycStart_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      slot_q     <= slot_d;
      zState_q   <= zState_d;
      holdCnt_q  <= holdCnt_d;
      fazDr_q    <= fazDr_d;
      faz2n_q    <= ~fazDr_d[1];
      isszDr_q   <= isszDr_d;
      phaseOut_q <= slot_q;
      cycStart_q <= cycStart_d;
    end
  end

  assign bus.FAZ1DR    = fazDr_q[0];
  assign bus.FAZ2DR    = fazDr_q[1];
  assign bus.FAZ2DR_n  = faz2n_q;
  assign bus.FAZ3DR    = fazDr_q[2];
  assign bus.FAZ4DR    = fazDr_q[3];
  assign bus.ISSZDR    = isszDr_q;
  assign bus.phase     = phaseOut_q;
  assign bus.cyc_start = cycStart_q;

endmodule

// File: tb/tb_phase_drive_gen.sv
// Directed bench for phase_drive_gen: a cycle model pushes expected outputs
// per edge into a scoreboard that is popped and compared after the edge.
module tb_phase_drive_gen;

  localparam int DIV = 4;
  localparam int ZH  = 16;
  localparam int CYC = 4 * DIV;
  localparam int ZI  = 0;
  localparam int ZW  = 1;
  localparam int ZHD = 2;
  localparam int ZR  = 3;

  typedef struct packed {
    logic [3:0] faz;
    logic       faz2n;
    logic       issz;
    logic [1:0] phase;
    logic       cyc;
  } expect_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  phase_drive_gen_if busA ();
  phase_drive_gen_if busB ();
  phase_drive_gen_if busC ();

  phase_drive_gen #(.DIV(DIV), .ZERO_HOLD(ZH)) dutA (.clk(clk), .rst(rst), .bus(busA));
  phase_drive_gen #(.DIV(2),   .ZERO_HOLD(3))  dutB (.clk(clk), .rst(rst), .bus(busB));
  phase_drive_gen #(.DIV(5),   .ZERO_HOLD(3))  dutC (.clk(clk), .rst(rst), .bus(busC));

  expect_t sbQueue[$];
  int      compareCount  = 0;
  int      mismatchCount = 0;

  int      mTick  = 0;
  int      mZ     = ZI;
  int      mCnt   = 0;
  logic    mSync1 = 1'b1;
  logic    mSync2 = 1'b1;
  logic    mIssz  = 1'b1;
  logic    lastRst = 1'b1;

  task automatic compareField(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      mismatchCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the expectation for the edge just taken and compare every DUT output.
  task automatic checkOutput();
    expect_t    x;
    logic [3:0] fazObs;
    int         auxExp;
    if (sbQueue.size() == 0) begin
      compareField("scoreboardEmpty", 32'd0, 32'd1);
      return;
    end
    x = sbQueue.pop_front();
    fazObs = {busA.FAZ4DR, busA.FAZ3DR, busA.FAZ2DR, busA.FAZ1DR};
    compareField("fazDr",    32'(fazObs),         32'(x.faz));
    compareField("faz2n",    32'(busA.FAZ2DR_n),  32'(x.faz2n));
    compareField("isszDr",   32'(busA.ISSZDR),    32'(x.issz));
    compareField("phase",    32'(busA.phase),     32'(x.phase));
    compareField("cycStart", 32'(busA.cyc_start), 32'(x.cyc));
    auxExp = lastRst ? 4 : 3;
    compareField("oneLowDiv2", 32'($countones({busB.FAZ4DR, busB.FAZ3DR, busB.FAZ2DR, busB.FAZ1DR})), 32'(auxExp));
    compareField("oneLowDiv5", 32'($countones({busC.FAZ4DR, busC.FAZ3DR, busC.FAZ2DR, busC.FAZ1DR})), 32'(auxExp));
  endtask

  // Drive one edge's inputs, predict the registered outputs, take the edge, check.
  task automatic applyStimulus(input logic r, input logic e, input logic iz);
    expect_t x;
    int      slot;
    logic    zreq;
    logic    cyc;
    rst       = r;
    busA.en   = e;
    busA.ISSZ = iz;
    busB.en   = 1'b1;
    busC.en   = 1'b1;
    x = '0;
    if (r) begin
      x.faz   = 4'hF;
      x.faz2n = 1'b0;
      x.issz  = 1'b1;
      x.phase = 2'd0;
      x.cyc   = 1'b0;
      mTick = 0; mZ = ZI; mCnt = 0;
      mSync1 = 1'b1; mSync2 = 1'b1; mIssz = 1'b1;
    end else begin
      slot    = mTick / DIV;
      cyc     = e && (mTick == 0);
      x.faz   = e ? (4'hF ^ (4'b0001 << slot)) : 4'hF;
      x.faz2n = ~x.faz[1];
      x.phase = 2'(slot);
      x.cyc   = cyc;
      zreq    = ~mSync2;
      case (mZ)
        ZI: if (zreq) mZ = ZW;
        ZW: begin
          if (!zreq) mZ = ZI;
          else if (cyc) begin mZ = ZHD; mCnt = 1; mIssz = 1'b0; end
        end
        ZHD: begin
          if (mCnt >= ZH) mZ = ZR;
          else mCnt = mCnt + 1;
        end
        default: if (cyc && !zreq) begin mZ = ZI; mIssz = 1'b1; end
      endcase
      x.issz = mIssz;
      mSync2 = mSync1;
      mSync1 = iz;
      if (e) mTick = (mTick + 1) % CYC;
    end
    sbQueue.push_back(x);
    lastRst = r;
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int   lowCount;
    logic prevIssz;
    busA.en = 1'b0; busA.ISSZ = 1'b1;
    busB.en = 1'b1; busB.ISSZ = 1'b1;
    busC.en = 1'b1; busC.ISSZ = 1'b1;

    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1);

    // Clock numbering from the first running edge: FAZ1 at 1-4 and 17.
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      compareField("t1Faz1", 32'(busA.FAZ1DR), (i <= 4 || i == 17) ? 32'd0 : 32'd1);
      compareField("t1Faz3", 32'(busA.FAZ3DR), (i >= 9 && i <= 12) ? 32'd0 : 32'd1);
      compareField("t1Cyc",  32'(busA.cyc_start), (i == 1 || i == 17) ? 32'd1 : 32'd0);
    end

    while (mTick != 2 * DIV + 1) applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (10) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      compareField("t3HoldPhase", 32'(busA.phase), 32'd2);
      compareField("t3HoldFaz", 32'({busA.FAZ4DR, busA.FAZ3DR, busA.FAZ2DR, busA.FAZ1DR}), 32'hF);
    end
    repeat (3) begin
      applyStimulus(1'b0, 1'b1, 1'b1);
      compareField("t3ResumeFaz3", 32'(busA.FAZ3DR), 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    compareField("t3NextFaz4", 32'(busA.FAZ4DR), 32'd0);

    while (mTick != DIV + 2) applyStimulus(1'b0, 1'b1, 1'b1);
    lowCount = 0;
    prevIssz = busA.ISSZDR;
    for (int i = 0; i < 20 + 3 * CYC; i++) begin
      applyStimulus(1'b0, 1'b1, (i < 20) ? 1'b0 : 1'b1);
      if (busA.ISSZDR == 1'b0) lowCount++;
      if (prevIssz == 1'b0 && busA.ISSZDR == 1'b1)
        compareField("t4RiseOnCyc", 32'(busA.cyc_start), 32'd1);
      prevIssz = busA.ISSZDR;
    end
    compareField("t4LowLen", 32'(lowCount), 32'd32);

    while (mTick != DIV) applyStimulus(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 23; i++) begin
      applyStimulus(1'b0, 1'b1, (i < 3) ? 1'b0 : 1'b1);
      compareField("t5GlitchIssz", 32'(busA.ISSZDR), 32'd1);
    end

    while (mZ != ZHD) applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0);
    compareField("t6InHold", 32'(busA.ISSZDR), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    compareField("t6RstIssz", 32'(busA.ISSZDR), 32'd1);
    compareField("t6RstPhase", 32'(busA.phase), 32'd0);
    compareField("t6RstFaz", 32'({busA.FAZ4DR, busA.FAZ3DR, busA.FAZ2DR, busA.FAZ1DR}), 32'hF);
    applyStimulus(1'b0, 1'b1, 1'b1);
    compareField("t6RestartFaz1", 32'(busA.FAZ1DR), 32'd0);
    compareField("t6RestartCyc", 32'(busA.cyc_start), 32'd1);
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b1);

    repeat (1000) applyStimulus(1'b0, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
